// File: rtl/ex_mem_branch_stage_if.sv
// EX -> EX/MEM boundary bundle: EX instruction fields, MEM-side register outputs,
// next-PC redirect handshake and branch statistics.
interface ex_mem_branch_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();
  logic             ex_valid;
  logic             ex_ready;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [4:0]       ex_rd;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic [XLEN-1:0]  alu_result;
  logic             alu_bcond;
  logic             mem_stall;
  logic             mem_valid;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_rs2_data;
  logic [4:0]       mem_rd;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Environment side: drives EX fields and the fetch/MEM back-pressure.
  modport master (
    output ex_valid, ex_pc, ex_imm, ex_rs2_data, ex_rd,
           ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           alu_result, alu_bcond, mem_stall, redirect_ready,
    input  ex_ready, mem_valid, mem_alu_result, mem_rs2_data, mem_rd,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg,
           redirect_valid, redirect_pc, branch_cnt, taken_cnt
  );

  // Stage side.
  modport slave (
    input  ex_valid, ex_pc, ex_imm, ex_rs2_data, ex_rd,
           ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           alu_result, alu_bcond, mem_stall, redirect_ready,
    output ex_ready, mem_valid, mem_alu_result, mem_rs2_data, mem_rd,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg,
           redirect_valid, redirect_pc, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/JAL/JALR resolution, a held next-PC redirect
// (RUN/HOLD FSM) and wrapping branch statistics counters.
module ex_mem_branch_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  ex_mem_branch_stage_if.slave  bus
);
  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [XLEN-1:0] LINK_OFS = XLEN'(3'd4);
  localparam logic [XLEN-1:0] LSB_ONE  = XLEN'(1'b1);

  state_t           state_r, state_nxt_s;
  logic             ex_ready_s, accept_s;
  logic             is_jalr_s, is_jal_s, is_br_s, taken_s;
  logic [XLEN-1:0]  target_s, link_s, result_s;
  logic             redirect_valid_r, redirect_valid_nxt_s;
  logic [XLEN-1:0]  redirect_pc_r, redirect_pc_nxt_s;
  logic             mem_valid_r;
  logic [XLEN-1:0]  mem_alu_result_r, mem_rs2_data_r;
  logic [4:0]       mem_rd_r;
  logic             mem_mem_read_r, mem_mem_write_r, mem_reg_write_r, mem_mem_to_reg_r;
  logic [CNT_W-1:0] branch_cnt_r, taken_cnt_r;

  assign ex_ready_s = (state_r == RUN) & ~bus.mem_stall;
  assign accept_s   = bus.ex_valid & ex_ready_s;

  // Decode with jalr > jal > branch priority; pick target and link/result values.
  always_comb begin
    is_jalr_s = bus.ex_is_jalr;
    is_jal_s  = bus.ex_is_jal & ~bus.ex_is_jalr;
    is_br_s   = bus.ex_is_branch & ~bus.ex_is_jal & ~bus.ex_is_jalr;
    taken_s   = (is_br_s & bus.alu_bcond) | is_jal_s | is_jalr_s;
    link_s    = bus.ex_pc + LINK_OFS;
    if (is_jalr_s) begin
      target_s = bus.alu_result & ~LSB_ONE;
    end else begin
      target_s = bus.ex_pc + bus.ex_imm;
    end
    if (is_jalr_s || is_jal_s) begin
      result_s = link_s;
    end else begin
      result_s = bus.alu_result;
    end
  end

  // Next-state and redirect outputs; redirect is captured once and frozen while in HOLD.
  always_comb begin
    state_nxt_s          = state_r;
    redirect_valid_nxt_s = redirect_valid_r;
    redirect_pc_nxt_s    = redirect_pc_r;
    case (state_r)
      RUN: begin
        if (accept_s && taken_s) begin
          state_nxt_s          = HOLD;
          redirect_valid_nxt_s = 1'b1;
          redirect_pc_nxt_s    = target_s;
        end else begin
          state_nxt_s          = RUN;
          redirect_valid_nxt_s = 1'b0;
        end
      end
      HOLD: begin
        if (bus.redirect_ready) begin
          state_nxt_s          = RUN;
          redirect_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s          = HOLD;
        end
      end
      default: begin
        state_nxt_s          = RUN;
        redirect_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= RUN;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      state_r          <= state_nxt_s;
      redirect_valid_r <= redirect_valid_nxt_s;
      redirect_pc_r    <= redirect_pc_nxt_s;
    end
  end

  // EX/MEM register: load on accept, drain valid when MEM is free, freeze on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_r      <= 1'b0;
      mem_alu_result_r <= '0;
      mem_rs2_data_r   <= '0;
      mem_rd_r         <= 5'd0;
      mem_mem_read_r   <= 1'b0;
      mem_mem_write_r  <= 1'b0;
      mem_reg_write_r  <= 1'b0;
      mem_mem_to_reg_r <= 1'b0;
    end else if (accept_s) begin
      mem_valid_r      <= 1'b1;
      mem_alu_result_r <= result_s;
      mem_rs2_data_r   <= bus.ex_rs2_data;
      mem_rd_r         <= bus.ex_rd;
      mem_mem_read_r   <= bus.ex_mem_read;
      mem_mem_write_r  <= bus.ex_mem_write;
      mem_reg_write_r  <= bus.ex_reg_write;
      mem_mem_to_reg_r <= bus.ex_mem_to_reg;
    end else if (!bus.mem_stall) begin
      mem_valid_r      <= 1'b0;
    end else begin
      mem_valid_r      <= mem_valid_r;
    end
  end

  // Statistics counters; natural wrap at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_r <= '0;
      taken_cnt_r  <= '0;
    end else if (accept_s) begin
      branch_cnt_r <= branch_cnt_r + CNT_W'(is_br_s);
      taken_cnt_r  <= taken_cnt_r + CNT_W'(taken_s);
    end else begin
      branch_cnt_r <= branch_cnt_r;
      taken_cnt_r  <= taken_cnt_r;
    end
  end

  assign bus.ex_ready       = ex_ready_s;
  assign bus.mem_valid      = mem_valid_r;
  assign bus.mem_alu_result = mem_alu_result_r;
  assign bus.mem_rs2_data   = mem_rs2_data_r;
  assign bus.mem_rd         = mem_rd_r;
  assign bus.mem_mem_read   = mem_mem_read_r;
  assign bus.mem_mem_write  = mem_mem_write_r;
  assign bus.mem_reg_write  = mem_reg_write_r;
  assign bus.mem_mem_to_reg = mem_mem_to_reg_r;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.branch_cnt     = branch_cnt_r;
  assign bus.taken_cnt      = taken_cnt_r;
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed bench for ex_mem_branch_stage; a second instance with 2-bit counters
// mirrors the stimulus so counter wrap can be reached in a few jumps.
module tb_ex_mem_branch_stage;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  ex_mem_branch_stage_if #(.XLEN(32), .CNT_W(32)) bif ();
  ex_mem_branch_stage_if #(.XLEN(32), .CNT_W(2))  sif ();

  ex_mem_branch_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  ex_mem_branch_stage #(.XLEN(32), .CNT_W(2)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  assign sif.ex_valid       = bif.ex_valid;
  assign sif.ex_pc          = bif.ex_pc;
  assign sif.ex_imm         = bif.ex_imm;
  assign sif.ex_rs2_data    = bif.ex_rs2_data;
  assign sif.ex_rd          = bif.ex_rd;
  assign sif.ex_is_branch   = bif.ex_is_branch;
  assign sif.ex_is_jal      = bif.ex_is_jal;
  assign sif.ex_is_jalr     = bif.ex_is_jalr;
  assign sif.ex_mem_read    = bif.ex_mem_read;
  assign sif.ex_mem_write   = bif.ex_mem_write;
  assign sif.ex_reg_write   = bif.ex_reg_write;
  assign sif.ex_mem_to_reg  = bif.ex_mem_to_reg;
  assign sif.alu_result     = bif.alu_result;
  assign sif.alu_bcond      = bif.alu_bcond;
  assign sif.mem_stall      = bif.mem_stall;
  assign sif.redirect_ready = bif.redirect_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt = total_cnt + 1;
    if (got === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.ex_valid       = 1'b0;
    bif.ex_pc          = 32'h0;
    bif.ex_imm         = 32'h0;
    bif.ex_rs2_data    = 32'h0;
    bif.ex_rd          = 5'd0;
    bif.ex_is_branch   = 1'b0;
    bif.ex_is_jal      = 1'b0;
    bif.ex_is_jalr     = 1'b0;
    bif.ex_mem_read    = 1'b0;
    bif.ex_mem_write   = 1'b0;
    bif.ex_reg_write   = 1'b0;
    bif.ex_mem_to_reg  = 1'b0;
    bif.alu_result     = 32'h0;
    bif.alu_bcond      = 1'b0;
    bif.mem_stall      = 1'b0;
    bif.redirect_ready = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // Reset with every input at 1.
    reset              = 1'b1;
    bif.ex_valid       = 1'b1;
    bif.ex_pc          = 32'hFFFF_FFFF;
    bif.ex_imm         = 32'hFFFF_FFFF;
    bif.ex_rs2_data    = 32'hFFFF_FFFF;
    bif.ex_rd          = 5'h1F;
    bif.ex_is_branch   = 1'b1;
    bif.ex_is_jal      = 1'b1;
    bif.ex_is_jalr     = 1'b1;
    bif.ex_mem_read    = 1'b1;
    bif.ex_mem_write   = 1'b1;
    bif.ex_reg_write   = 1'b1;
    bif.ex_mem_to_reg  = 1'b1;
    bif.alu_result     = 32'hFFFF_FFFF;
    bif.alu_bcond      = 1'b1;
    bif.mem_stall      = 1'b1;
    bif.redirect_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_mem_valid", 64'(bif.mem_valid), 64'd0);
    check_eq("rst_mem_alu", 64'(bif.mem_alu_result), 64'd0);
    check_eq("rst_mem_rs2", 64'(bif.mem_rs2_data), 64'd0);
    check_eq("rst_mem_rd", 64'(bif.mem_rd), 64'd0);
    check_eq("rst_mem_ctrl", 64'({bif.mem_mem_read, bif.mem_mem_write, bif.mem_reg_write, bif.mem_mem_to_reg}), 64'd0);
    check_eq("rst_redir_valid", 64'(bif.redirect_valid), 64'd0);
    check_eq("rst_redir_pc", 64'(bif.redirect_pc), 64'd0);
    check_eq("rst_branch_cnt", 64'(bif.branch_cnt), 64'd0);
    check_eq("rst_taken_cnt", 64'(bif.taken_cnt), 64'd0);
    check_eq("rst_ex_ready", 64'(bif.ex_ready), 64'd0);

    // Plain ADD after reset release.
    reset = 1'b0;
    idle();
    bif.ex_valid     = 1'b1;
    bif.alu_result   = 32'h0000_0010;
    bif.ex_rd        = 5'd5;
    bif.ex_reg_write = 1'b1;
    bif.ex_rs2_data  = 32'h0000_DEAD;
    #1;
    check_eq("add_ex_ready", 64'(bif.ex_ready), 64'd1);
    tick();
    check_eq("add_mem_valid", 64'(bif.mem_valid), 64'd1);
    check_eq("add_mem_alu", 64'(bif.mem_alu_result), 64'h10);
    check_eq("add_mem_rd", 64'(bif.mem_rd), 64'd5);
    check_eq("add_mem_rw", 64'(bif.mem_reg_write), 64'd1);
    check_eq("add_mem_rs2", 64'(bif.mem_rs2_data), 64'hDEAD);

    // Taken BEQ, redirect held until redirect_ready.
    idle();
    bif.ex_valid     = 1'b1;
    bif.ex_is_branch = 1'b1;
    bif.ex_pc        = 32'h0000_0100;
    bif.ex_imm       = 32'h0000_0020;
    bif.alu_bcond    = 1'b1;
    tick();
    idle();
    bif.ex_valid     = 1'b1;
    bif.alu_result   = 32'h0000_0999;
    bif.ex_reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bif.redirect_ready = 1'b1;
      #1;
      check_eq("beq_redir_valid", 64'(bif.redirect_valid), 64'd1);
      check_eq("beq_redir_pc", 64'(bif.redirect_pc), 64'h120);
      check_eq("beq_ex_ready", 64'(bif.ex_ready), 64'd0);
      check_eq("beq_branch_cnt", 64'(bif.branch_cnt), 64'd1);
      check_eq("beq_taken_cnt", 64'(bif.taken_cnt), 64'd1);
      check_eq("beq_mem_valid", 64'(bif.mem_valid), (i == 0) ? 64'd1 : 64'd0);
      tick();
    end
    check_eq("beq_release_valid", 64'(bif.redirect_valid), 64'd0);
    check_eq("beq_release_ready", 64'(bif.ex_ready), 64'd1);
    idle();

    // Not-taken BNE.
    bif.ex_valid     = 1'b1;
    bif.ex_is_branch = 1'b1;
    bif.ex_pc        = 32'h0000_0140;
    bif.ex_imm       = 32'h0000_0040;
    tick();
    idle();
    #1;
    check_eq("bne_redir_valid", 64'(bif.redirect_valid), 64'd0);
    check_eq("bne_branch_cnt", 64'(bif.branch_cnt), 64'd2);
    check_eq("bne_taken_cnt", 64'(bif.taken_cnt), 64'd1);
    check_eq("bne_ex_ready", 64'(bif.ex_ready), 64'd1);
    check_eq("bne_mem_valid", 64'(bif.mem_valid), 64'd1);

    // JALR: target clears bit 0, link is pc+4.
    bif.ex_valid     = 1'b1;
    bif.ex_is_jalr   = 1'b1;
    bif.ex_pc        = 32'h0000_0200;
    bif.alu_result   = 32'h0000_0333;
    bif.ex_rd        = 5'd1;
    bif.ex_reg_write = 1'b1;
    tick();
    idle();
    bif.redirect_ready = 1'b1;
    #1;
    check_eq("jalr_redir_valid", 64'(bif.redirect_valid), 64'd1);
    check_eq("jalr_redir_pc", 64'(bif.redirect_pc), 64'h332);
    check_eq("jalr_link", 64'(bif.mem_alu_result), 64'h204);
    check_eq("jalr_taken_cnt", 64'(bif.taken_cnt), 64'd2);
    check_eq("jalr_ex_ready", 64'(bif.ex_ready), 64'd0);
    tick();
    check_eq("jalr_release", 64'(bif.redirect_valid), 64'd0);

    // JAL across the top of the address space; redirect_ready already high.
    bif.ex_valid   = 1'b1;
    bif.ex_is_jal  = 1'b1;
    bif.ex_pc      = 32'hFFFF_FFFC;
    bif.ex_imm     = 32'h0000_0008;
    tick();
    idle();
    bif.redirect_ready = 1'b1;
    #1;
    check_eq("jal_redir_pc", 64'(bif.redirect_pc), 64'h4);
    check_eq("jal_link_wrap", 64'(bif.mem_alu_result), 64'h0);
    check_eq("jal_taken_cnt", 64'(bif.taken_cnt), 64'd3);
    check_eq("jal_small_taken", 64'(sif.taken_cnt), 64'd3);
    tick();
    check_eq("jal_release", 64'(bif.redirect_valid), 64'd0);

    // MEM stall freezes the register and blocks acceptance.
    idle();
    bif.ex_valid     = 1'b1;
    bif.alu_result   = 32'h0000_AAAA;
    bif.ex_rd        = 5'd7;
    bif.ex_mem_write = 1'b1;
    bif.ex_rs2_data  = 32'h0000_0055;
    tick();
    check_eq("st_pre_alu", 64'(bif.mem_alu_result), 64'hAAAA);
    bif.mem_stall    = 1'b1;
    bif.alu_result   = 32'h0000_BBBB;
    bif.ex_rd        = 5'd9;
    bif.ex_mem_write = 1'b0;
    bif.ex_mem_read  = 1'b1;
    bif.ex_rs2_data  = 32'h0000_0066;
    #1;
    check_eq("st_ex_ready", 64'(bif.ex_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("st_hold_valid", 64'(bif.mem_valid), 64'd1);
      check_eq("st_hold_alu", 64'(bif.mem_alu_result), 64'hAAAA);
      check_eq("st_hold_rd", 64'(bif.mem_rd), 64'd7);
      check_eq("st_hold_rs2", 64'(bif.mem_rs2_data), 64'h55);
      check_eq("st_hold_ctrl", 64'({bif.mem_mem_read, bif.mem_mem_write}), 64'b01);
    end
    bif.mem_stall = 1'b0;
    #1;
    check_eq("st_drop_ready", 64'(bif.ex_ready), 64'd1);
    tick();
    check_eq("st_acc_alu", 64'(bif.mem_alu_result), 64'hBBBB);
    check_eq("st_acc_rd", 64'(bif.mem_rd), 64'd9);
    check_eq("st_acc_read", 64'(bif.mem_mem_read), 64'd1);
    idle();
    tick();
    check_eq("drain_valid", 64'(bif.mem_valid), 64'd0);
    check_eq("drain_alu_hold", 64'(bif.mem_alu_result), 64'hBBBB);

    // Conflicting flags: jalr wins over branch; redirect left pending.
    bif.ex_valid     = 1'b1;
    bif.ex_is_branch = 1'b1;
    bif.ex_is_jalr   = 1'b1;
    bif.ex_pc        = 32'h0000_0300;
    bif.ex_imm       = 32'h0000_0010;
    bif.alu_result   = 32'h0000_1001;
    tick();
    idle();
    #1;
    check_eq("cfl_redir_valid", 64'(bif.redirect_valid), 64'd1);
    check_eq("cfl_redir_pc", 64'(bif.redirect_pc), 64'h1000);
    check_eq("cfl_link", 64'(bif.mem_alu_result), 64'h304);
    check_eq("cfl_taken_cnt", 64'(bif.taken_cnt), 64'd4);
    check_eq("cfl_small_wrap", 64'(sif.taken_cnt), 64'd0);

    // Reset while in HOLD drops the redirect.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rh_redir_valid", 64'(bif.redirect_valid), 64'd0);
    check_eq("rh_redir_pc", 64'(bif.redirect_pc), 64'd0);
    check_eq("rh_taken_cnt", 64'(bif.taken_cnt), 64'd0);
    check_eq("rh_branch_cnt", 64'(bif.branch_cnt), 64'd0);
    check_eq("rh_mem_valid", 64'(bif.mem_valid), 64'd0);
    check_eq("rh_ex_ready", 64'(bif.ex_ready), 64'd1);

    // Jumps to drive the 2-bit counter through its maximum and back to zero.
    for (int k = 0; k < 4; k++) begin
      bif.ex_valid  = 1'b1;
      bif.ex_is_jal = 1'b1;
      bif.ex_pc     = 32'h0000_0400;
      bif.ex_imm    = 32'h0000_0010;
      tick();
      idle();
      bif.redirect_ready = 1'b1;
      #1;
      check_eq("wrap_small_taken", 64'(sif.taken_cnt), 64'((k + 1) % 4));
      check_eq("wrap_main_taken", 64'(bif.taken_cnt), 64'(k + 1));
      check_eq("wrap_redir_pc", 64'(bif.redirect_pc), 64'h410);
      tick();
      bif.redirect_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
